// File: rtl/config_stream_master.sv
// config_stream_master
// Turns a byte stream of write frames into single-cycle writes on the tile
// configuration bus. Frame layout:
//   B0 = tile index, B1 = {len[5:0], addr[9:8]}, B2 = addr[7:0],
//   then len+1 data bytes, each written to tile[idx] at addr, addr+1, ...
// The frame format carries a 10-bit address, so ADDR_W must be 10.
//
// Handshake: a byte is transferred on a rising edge of conf where
// s_valid & s_ready are both high. s_ready depends only on enable and abort,
// never on s_valid, and the source may change s_data freely while s_valid
// is low.
module config_stream_master #(
    parameter int NB_TILES = 16,
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 8
) (
    input  logic                conf,
    input  logic                reset,
    input  logic                enable,
    input  logic                abort,
    input  logic [DATA_W-1:0]   s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic [NB_TILES-1:0] select_tile,
    output logic [ADDR_W-1:0]   address_tile,
    output logic [DATA_W-1:0]   data_tile,
    output logic                busy,
    output logic                frame_done,
    output logic                err_bad_tile,
    output logic [2:0]          dbg_state
);

    typedef enum logic [2:0] {
        S_TILE = 3'd0,
        S_HDR1 = 3'd1,
        S_HDR2 = 3'd2,
        S_DATA = 3'd3,
        S_SKIP = 3'd4
    } state_t;

    localparam logic [NB_TILES-1:0] SEL_ONE  = NB_TILES'(1);
    localparam logic [8:0]          TILE_LIM = 9'(NB_TILES);

    state_t              state_q,   state_d;
    logic [7:0]          tile_q,    tile_d;
    logic                bad_q,     bad_d;
    logic [5:0]          count_q,   count_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic [NB_TILES-1:0] select_q,  select_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic [DATA_W-1:0]   data_q,    data_d;
    logic                done_q,    done_d;
    logic                err_q,     err_d;
    logic                accept;

    assign s_ready      = enable & ~abort;
    assign accept       = s_valid & s_ready;
    assign select_tile  = select_q;
    assign address_tile = address_q;
    assign data_tile    = data_q;
    assign frame_done   = done_q;
    assign err_bad_tile = err_q;
    assign busy         = (state_q != S_TILE);
    assign dbg_state    = state_q;

    // Frame parser: next state, burst counter/address and the registered write.
    always_comb begin
        state_d   = state_q;
        tile_d    = tile_q;
        bad_d     = bad_q;
        count_d   = count_q;
        addr_d    = addr_q;
        select_d  = '0;
        address_d = address_q;
        data_d    = data_q;
        done_d    = 1'b0;
        err_d     = err_q;

        if (abort) begin
            // Abort wins over any byte this cycle; the write registered on
            // the previous edge is already on the bus and is left alone.
            state_d = S_TILE;
            count_d = '0;
            bad_d   = 1'b0;
        end else if (accept) begin
            case (state_q)
                S_TILE: begin
                    tile_d  = s_data;
                    bad_d   = ({1'b0, s_data} >= TILE_LIM);
                    if ({1'b0, s_data} >= TILE_LIM) begin
                        err_d = 1'b1;
                    end
                    state_d = S_HDR1;
                end
                S_HDR1: begin
                    // Length goes straight into the counter; it is not
                    // touched again until the data phase starts.
                    count_d      = s_data[7:2];
                    addr_d[9:8]  = s_data[1:0];
                    state_d      = S_HDR2;
                end
                S_HDR2: begin
                    addr_d[7:0] = s_data;
                    state_d     = bad_q ? S_SKIP : S_DATA;
                end
                S_DATA: begin
                    select_d  = SEL_ONE << tile_q;
                    address_d = addr_q;
                    data_d    = s_data;
                    if (count_q == 6'd0) begin
                        state_d = S_TILE;
                        done_d  = 1'b1;
                    end else begin
                        count_d = count_q - 6'd1;
                        // Natural wrap at 2^ADDR_W inside a burst.
                        addr_d  = addr_q + ADDR_W'(1);
                    end
                end
                S_SKIP: begin
                    if (count_q == 6'd0) begin
                        state_d = S_TILE;
                        done_d  = 1'b1;
                    end else begin
                        count_d = count_q - 6'd1;
                    end
                end
                default: state_d = S_TILE;
            endcase
        end
    end

    // State and output registers; reset drops any frame in progress at once.
    always_ff @(posedge conf or posedge reset) begin
        if (reset) begin
            state_q   <= S_TILE;
            tile_q    <= '0;
            bad_q     <= 1'b0;
            count_q   <= '0;
            addr_q    <= '0;
            select_q  <= '0;
            address_q <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tile_q    <= tile_d;
            bad_q     <= bad_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            select_q  <= select_d;
            address_q <= address_d;
            data_q    <= data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

endmodule
